// File: rtl/config_pkg.sv
// Core configuration record. The init sequencer only carries it through, so
// this slice holds just the fields the cache checks for sanity.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/std_cache_pkg.sv
// Shared types and geometry of the standard non-blocking L1 data cache,
// including the state type of the invalidate-all sequencer.
package std_cache_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH  = 128;
  localparam int unsigned DCACHE_NUM_WORDS   = 256;
  localparam int unsigned DCACHE_SET_ASSOC   = 8;
  localparam int unsigned DCACHE_BYTE_OFFSET = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned DCACHE_INDEX_WIDTH = $clog2(DCACHE_NUM_WORDS) + DCACHE_BYTE_OFFSET;

  // One dirty bit per byte of the line plus the line valid bit.
  typedef struct packed {
    logic [DCACHE_LINE_WIDTH/8-1:0] dirty;
    logic                           valid;
  } vldrty_t;

  typedef enum logic [1:0] {
    RST,
    CLEAR,
    IDLE
  } init_state_e;

endpackage

// File: rtl/dcache_init_sequencer.sv
// Walks every set of the L1 data cache and clears valid/dirty in all ways,
// once after reset (unless init_ni is low) and on every invalidate-all request.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RST   | first cycle after reset; samples init_ni
//   CLEAR | issuing one valid/dirty clear per set through the arbiter slot
//   IDLE  | cache usable; waits for inv_req_i
module dcache_init_sequencer
  import std_cache_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NumWords   = DCACHE_NUM_WORDS,
  parameter int unsigned           SetAssoc   = DCACHE_SET_ASSOC,
  parameter int unsigned           IndexWidth = DCACHE_INDEX_WIDTH,
  parameter int unsigned           ByteOffset = DCACHE_BYTE_OFFSET
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           init_ni,
  input  logic                           inv_req_i,
  output logic                           inv_ack_o,
  output logic                           busy_o,
  output logic [SetAssoc-1:0]            req_o,
  output logic [IndexWidth-1:0]          addr_o,
  output logic                           we_o,
  output vldrty_t [SetAssoc-1:0]         be_o,
  input  logic                           gnt_i
);

  localparam int unsigned IdxW = $clog2(NumWords);

  if (NumWords < 2 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_num_words
    $error("dcache_init_sequencer: NumWords must be a power of two >= 2");
  end
  if (IndexWidth < IdxW + ByteOffset) begin : g_bad_index_width
    $error("dcache_init_sequencer: IndexWidth too narrow for NumWords and ByteOffset");
  end
  if (CVA6Cfg.XLEN != 0 && CVA6Cfg.XLEN != 32 && CVA6Cfg.XLEN != 64) begin : g_bad_xlen
    $error("dcache_init_sequencer: unsupported XLEN in core configuration");
  end

  init_state_e           state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  ack_q, ack_d;
  logic [SetAssoc-1:0]   req_q;
  logic                  we_q;
  logic                  busy_q;
  vldrty_t [SetAssoc-1:0] be_q, be_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    unique case (state_q)
      RST: begin
        idx_d   = '0;
        state_d = init_ni ? CLEAR : IDLE;
      end
      // The request is still high during the ack cycle; only a request that
      // survives past the ack starts another walk.
      IDLE: begin
        if (inv_req_i && !ack_q) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (gnt_i) begin
          if (idx_q == IdxW'(NumWords - 1)) begin
            state_d = IDLE;
            ack_d   = inv_req_i;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = RST;
    endcase
  end

  always_comb begin
    be_d = '0;
    if (state_d == CLEAR) be_d = '1;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      req_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      req_q   <= {SetAssoc{state_d == CLEAR}};
      we_q    <= (state_d == CLEAR);
      be_q    <= be_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign inv_ack_o = ack_q;
  assign busy_o    = busy_q;
  assign req_o     = req_q;
  assign we_o      = we_q;
  assign be_o      = be_q;
  assign addr_o    = IndexWidth'(idx_q) << ByteOffset;

endmodule

// File: tb/tb_dcache_init_sequencer.sv
// Randomised bench for the dcache init sequencer: a flag-level model of the
// walk is compared with the DUT every cycle, plus directed literal checks.
module tb_dcache_init_sequencer;
  import std_cache_pkg::*;

  localparam int NW  = DCACHE_NUM_WORDS;
  localparam int SA  = DCACHE_SET_ASSOC;
  localparam int BO  = DCACHE_BYTE_OFFSET;
  localparam int IW  = DCACHE_INDEX_WIDTH;
  localparam int BEW = SA * $bits(vldrty_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_n = 1'b1;
  logic inv_req = 1'b0;
  logic gnt = 1'b0;
  logic inv_ack, busy, we;
  logic [SA-1:0] req;
  logic [IW-1:0] addr;
  vldrty_t [SA-1:0] be;

  dcache_init_sequencer dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .init_ni  (init_n),
    .inv_req_i(inv_req),
    .inv_ack_o(inv_ack),
    .busy_o   (busy),
    .req_o    (req),
    .addr_o   (addr),
    .we_o     (we),
    .be_o     (be),
    .gnt_i    (gnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: "booting" = the single post-reset cycle, "walking" =
  // a walk in progress at set m_idx, m_ack = walk just finished with a request.
  bit m_boot = 1'b1;
  bit m_walk = 1'b0;
  bit m_ack  = 1'b0;
  int m_idx  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_walk = 1'b0; m_ack = 1'b0; m_idx = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_ack  = 1'b0;
      if (init_n) begin m_walk = 1'b1; m_idx = 0; end
    end else if (m_walk) begin
      m_ack = 1'b0;
      if (gnt) begin
        if (m_idx == NW - 1) begin m_walk = 1'b0; m_ack = inv_req; end
        else m_idx = m_idx + 1;
      end
    end else begin
      if (inv_req && !m_ack) begin m_walk = 1'b1; m_idx = 0; end
      m_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_boot || m_walk);
    chk("req", req, m_walk ? {SA{1'b1}} : '0);
    chk("we", we, m_walk);
    chk("be", be, m_walk ? {BEW{1'b1}} : '0);
    chk("addr", addr, m_idx << BO);
    chk("ack", inv_ack, m_ack);
  end

  // Every set must receive exactly one granted write per walk.
  int hits[NW];
  always @(posedge clk) if (rst_n && req[0] && gnt) hits[int'(addr >> BO)]++;

  task automatic clear_hits();
    for (int i = 0; i < NW; i++) hits[i] = 0;
  endtask

  task automatic cov_check(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < NW; i++) if (hits[i] != 1) nbad++;
    chk(name, nbad, 0);
  endtask

  int gnt_mode = 0;  // 0 = tied high, 1 = toggling, 2 = random

  task automatic step();
    @(posedge clk);
    #2;
    case (gnt_mode)
      0:       gnt = 1'b1;
      1:       gnt = ~gnt;
      default: gnt = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_to_idle(output int n, output int acks);
    n = 0; acks = 0;
    while (busy && n < 4000) begin
      n++;
      if (inv_ack) acks++;
      step();
    end
    chk("walk_timeout", busy, 0);
  endtask

  task automatic apply_reset(input bit init);
    rst_n = 1'b0; init_n = init; inv_req = 1'b0;
    repeat (3) step();
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_be", be, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ack", inv_ack, 0);
    chk("rst_busy", busy, 1);
    clear_hits();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, w, first, cyc;

    // A: post-reset walk, grant tied high
    gnt_mode = 0; gnt = 1'b1;
    apply_reset(1'b1);
    first = -1; cyc = 1; n = 0;
    while (busy && n < 4000) begin
      if (req[0] && first < 0) first = cyc;
      n++; cyc++;
      step();
    end
    chk("A_first_req_cycle", first, 2);
    chk("A_busy_cycles", n, 257);
    chk("A_no_ack", inv_ack, 0);
    cov_check("A_cov");

    // B: request from IDLE, then a request held one cycle past the ack
    step(); step();
    inv_req = 1'b1; clear_hits();
    step();
    chk("B_req_next", req, {SA{1'b1}});
    chk("B_addr0", addr, 0);
    run_to_idle(n, a);
    chk("B_len", n, 256);
    chk("B_ack_early", a, 0);
    chk("B_ack", inv_ack, 1);
    cov_check("B_cov");
    step();
    chk("B_ack_pulse", inv_ack, 0);
    chk("B_busy_ack_next", busy, 0);
    step();
    chk("B_rewalk", busy, 1);
    inv_req = 1'b0; clear_hits();
    run_to_idle(n, a);
    chk("B2_len", n, 256);
    chk("B2_no_ack", inv_ack, 0);
    cov_check("B2_cov");

    // C: grant toggling 0,1,0,1 from the first CLEAR cycle
    step();
    inv_req = 1'b1; gnt = 1'b1; gnt_mode = 1; clear_hits();
    step();
    run_to_idle(n, a);
    chk("C_len", n, 512);
    chk("C_ack", inv_ack, 1);
    cov_check("C_cov");
    inv_req = 1'b0; gnt_mode = 0;
    step();
    chk("C_ack_pulse", inv_ack, 0);
    step();
    chk("C_stay_idle", busy, 0);

    // D: reset with the walk skipped
    apply_reset(1'b0);
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    chk("D_busy_cycles", n, 1);
    a = 0;
    repeat (10) begin if (req != 0) a++; step(); end
    chk("D_no_req", a, 0);

    // E: random grants, request raised at index 100 of the post-reset walk
    gnt_mode = 2;
    apply_reset(1'b1);
    w = 0;
    while (!(req[0] && addr == IW'(100 << BO)) && w < 4000) begin w++; step(); end
    chk("E_reach100", addr, 100 << BO);
    inv_req = 1'b1;
    run_to_idle(n, a);
    chk("E_ack_early", a, 0);
    chk("E_ack", inv_ack, 1);
    cov_check("E_cov");
    step();
    chk("E_ack_pulse", inv_ack, 0);
    inv_req = 1'b0;
    step(); step();
    chk("E_no_second_walk", busy, 0);

    // F: reset asserted at index 37 with a request pending
    gnt_mode = 0;
    apply_reset(1'b1);
    w = 0;
    while (!(req[0] && addr == IW'(20 << BO)) && w < 4000) begin w++; step(); end
    inv_req = 1'b1;
    while (!(req[0] && addr == IW'(37 << BO)) && w < 4000) begin w++; step(); end
    chk("F_reach37", addr, 37 << BO);
    rst_n = 1'b0;
    #1;
    chk("F_async_req", req, 0);
    chk("F_async_we", we, 0);
    chk("F_async_be", be, 0);
    chk("F_async_addr", addr, 0);
    chk("F_async_busy", busy, 1);
    chk("F_async_ack", inv_ack, 0);
    inv_req = 1'b0; gnt_mode = 2;
    repeat (2) step();
    clear_hits();
    rst_n = 1'b1;
    step();
    chk("F_restart_req", req, {SA{1'b1}});
    chk("F_restart_addr", addr, 0);
    run_to_idle(n, a);
    chk("F_no_ack_walk", a, 0);
    chk("F_no_ack_end", inv_ack, 0);
    cov_check("F_cov");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
